// File: rtl/divu_if.sv
// divu_if: request/response bundle between the ALU and the sequential unsigned
// divider.
//   start       request pulse; the divider samples it only while IDLE or DONE
//   dividend    unsigned dividend, sampled on the accepting edge
//   divisor     unsigned divisor, sampled on the accepting edge
//   busy        high while a division is iterating
//   done        one-cycle pulse when quotient/remainder become valid
//   quotient    registered quotient (Lo)
//   remainder   registered remainder (Hi)
//   div_by_zero registered with the results: that operation's divisor was 0
// The master modport is the ALU side. The slave modport is the divider side.
interface divu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/divu_engine.sv
// divu_engine: sequential restoring unsigned divider (DIVU responder).
// Each clock performs one shift-subtract step. A division of WIDTH-bit operands
// takes WIDTH steps. The results are registered. After that the engine produces
// a one-cycle done pulse and holds the results until the next completion.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    divu_if.slave: start/dividend/divisor in;
//          busy/done/quotient/remainder/div_by_zero out
module divu_engine #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic  clk,
  input  logic  reset,
  divu_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;
  logic   accept;
  logic   last_step;

  // Partial remainder. The restoring algorithm keeps R < D after every step,
  // so the top bit of the (WIDTH+1)-bit remainder is always zero between steps.
  // Only WIDTH bits are stored. The extra bit exists in the trial subtraction.
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic             z_reg;
  logic [CNT_W-1:0] count_reg;

  logic [WIDTH-1:0] quotient_reg;
  logic [WIDTH-1:0] remainder_reg;
  logic             div_by_zero_reg;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] r_step;
  logic [WIDTH-1:0] q_step;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  assign last_step = (count_reg == CNT_W'(WIDTH - 1));

  // ---------------- FSM: next-state logic ----------------
  // start is only looked at in IDLE/DONE. A request (or X) during RUN has no effect.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (last_step) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state_reg)
      RUN:     bus.busy = 1'b1;
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  // ---------------- one restoring step ----------------
  always_comb begin
    shifted = {r_reg, q_reg[WIDTH-1]};
    trial   = shifted - {1'b0, d_reg};
    if (!trial[WIDTH]) begin
      r_step = trial[WIDTH-1:0];
      q_step = {q_reg[WIDTH-2:0], 1'b1};
    end else begin
      r_step = shifted[WIDTH-1:0];
      q_step = {q_reg[WIDTH-2:0], 1'b0};
    end
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_reg           <= '0;
      q_reg           <= '0;
      d_reg           <= '0;
      z_reg           <= 1'b0;
      count_reg       <= '0;
      quotient_reg    <= '0;
      remainder_reg   <= '0;
      div_by_zero_reg <= 1'b0;
    end else if (accept) begin
      r_reg     <= '0;
      q_reg     <= bus.dividend;
      d_reg     <= bus.divisor;
      z_reg     <= (bus.divisor == '0);
      count_reg <= '0;
    end else if (state_reg == RUN) begin
      r_reg     <= r_step;
      q_reg     <= q_step;
      count_reg <= count_reg + CNT_W'(1);
      // The final step writes straight into the result registers, so
      // results are valid in the same cycle that done is asserted.
      if (last_step) begin
        quotient_reg    <= q_step;
        remainder_reg   <= r_step;
        div_by_zero_reg <= z_reg;
      end
    end
  end

  assign bus.quotient    = quotient_reg;
  assign bus.remainder   = remainder_reg;
  assign bus.div_by_zero = div_by_zero_reg;

endmodule

// File: tb/tb_divu_engine.sv
module tb_divu_engine;

  localparam int WIDTH = 32;
  localparam int LAT   = 32;

  logic clk;
  logic reset;
  int   cyc;
  int   total;
  int   bad;

  divu_if #(.WIDTH(WIDTH)) bus ();

  divu_engine #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
    int          acc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest pending op,
  // with the exact latency counted from its accept edge.
  always @(negedge clk) begin
    if (reset && bus.done) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done actual=1 required=0 t=%0t", $time);
      end else begin
        mon_e = sbq.pop_front();
        $display("op %0d / %0d -> q=%h r=%h z=%0d (lat %0d)", mon_e.a, mon_e.b,
                 bus.quotient, bus.remainder, bus.div_by_zero, cyc - mon_e.acc);
        chk("quotient", bus.quotient, mon_e.q);
        chk("remainder", bus.remainder, mon_e.r);
        chk("div_by_zero", 32'(bus.div_by_zero), 32'(mon_e.z));
        chk("latency", 32'(cyc - mon_e.acc), 32'(LAT));
      end
    end
  end

  task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] q, input logic [31:0] r,
                          input logic z, input bit sync);
    exp_t e;
    if (sync) @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    #1;
    e.a = a; e.b = b; e.q = q; e.r = r; e.z = z; e.acc = cyc;
    sbq.push_back(e);
    chk("busy_after_accept", 32'(bus.busy), 32'd1);
    bus.start    = 1'b0;
    bus.dividend = $urandom;
    bus.divisor  = $urandom;
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 200; i++) begin
      if (sbq.size() == 0) return;
      @(posedge clk);
    end
    total++;
    bad++;
    $display("FAIL done_timeout actual=%0d_pending required=0", sbq.size());
    sbq.delete();
  endtask

  vec_t vecs[8];

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    cyc          = 0;
    total        = 0;
    bad          = 0;
    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    vecs[0] = '{a: 32'd100,        b: 32'd7,          q: 32'd14,         r: 32'd2,    z: 1'b0};
    vecs[1] = '{a: 32'hFFFFFFFF,   b: 32'd1,          q: 32'hFFFFFFFF,   r: 32'd0,    z: 1'b0};
    vecs[2] = '{a: 32'd5,          b: 32'hFFFFFFFF,   q: 32'd0,          r: 32'd5,    z: 1'b0};
    vecs[3] = '{a: 32'd1234,       b: 32'd0,          q: 32'hFFFFFFFF,   r: 32'd1234, z: 1'b1};
    vecs[4] = '{a: 32'd0,          b: 32'd3,          q: 32'd0,          r: 32'd0,    z: 1'b0};
    vecs[5] = '{a: 32'd7,          b: 32'd7,          q: 32'd1,          r: 32'd0,    z: 1'b0};
    vecs[6] = '{a: 32'h80000000,   b: 32'd3,          q: 32'h2AAAAAAA,   r: 32'd2,    z: 1'b0};
    vecs[7] = '{a: 32'd6,          b: 32'd7,          q: 32'd0,          r: 32'd6,    z: 1'b0};

    // Reset state
    #12;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_quotient", bus.quotient, 32'd0);
    chk("rst_remainder", bus.remainder, 32'd0);
    chk("rst_dbz", 32'(bus.div_by_zero), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z, 1'b1);
      wait_empty();
      repeat (2) @(negedge clk);
    end

    // Random operands against a behavioural model
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      start_op(a, b, a / b, a % b, 1'b0, 1'b1);
      wait_empty();
    end

    // Start during RUN is ignored
    start_op(32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 1'b1);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 32'd9;
    bus.divisor  = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    wait_empty();
    repeat (4) @(negedge clk);

    // Reset in the middle of RUN: immediate clear, no done
    start_op(32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 1'b1);
    repeat (14) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    sbq.delete();
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_quotient", bus.quotient, 32'd0);
    chk("midrst_remainder", bus.remainder, 32'd0);
    repeat (25) @(negedge clk);
    reset = 1'b1;
    repeat (30) @(negedge clk);
    chk("midrst_no_result", bus.quotient, 32'd0);
    start_op(32'd81, 32'd9, 32'd9, 32'd0, 1'b0, 1'b1);
    wait_empty();

    // Back-to-back: start held during the DONE cycle
    start_op(32'd20, 32'd6, 32'd3, 32'd2, 1'b0, 1'b1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.done) break;
    end
    start_op(32'd50, 32'd8, 32'd6, 32'd2, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold_quotient", bus.quotient, 32'd3);
      chk("hold_remainder", bus.remainder, 32'd2);
    end
    wait_empty();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
